// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request, fault-report and data-memory bus for mem_access_unit
interface mem_access_unit_if #(parameter int AW = 10);
  logic          req_valid;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_sign;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [31:0]   ld_data;
  logic          stall;
  logic          exc;
  logic          exc_flag;
  logic [31:0]   bad_addr;
  logic          exc_clr;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din;
  logic          dm_wr;
  logic [31:0]   dm_dout;
  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, exc_clr, dm_dout,
    input  ld_data, stall, exc, exc_flag, bad_addr, dm_addr, dm_din, dm_wr
  );
  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, exc_clr, dm_dout,
    output ld_data, stall, exc, exc_flag, bad_addr, dm_addr, dm_din, dm_wr
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store front end with sub-word read-modify-write and sticky fault capture
module mem_access_unit #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input logic             clk,
  input logic             rst_n,
  mem_access_unit_if.slave bus
);
  typedef enum logic {IDLE, RMW} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      lane_q, lane_d;
  logic            half_q, half_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            exc_flag_q, exc_flag_d;
  logic [DW-1:0]   bad_addr_q, bad_addr_d;
  logic            idle_req, fault;
  logic [DW-1:0]   shifted, mask, ins;
  logic            unused;
  assign unused = ^bus.req_addr[31:AW+2];
  always_comb begin
    idle_req = rst_n && state_q == IDLE && bus.req_valid;
    fault = idle_req && (bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                         (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00));
    shifted = bus.dm_dout >> {bus.req_addr[1:0], 3'b000};
    // lane_q is byte-granular, so halves at lane 2 shift by 16 just like a byte at lane 2
    mask = (half_q ? 32'h0000_FFFF : 32'h0000_00FF) << {lane_q, 3'b000};
    ins = {16'b0, half_q ? wdata_q : {8'b0, wdata_q[7:0]}} << {lane_q, 3'b000};
    state_d = state_q;
    addr_d = addr_q;
    lane_d = lane_q;
    half_d = half_q;
    wdata_d = wdata_q;
    bus.dm_addr = state_q == RMW ? addr_q : bus.req_addr[AW+1:2];
    bus.dm_din = state_q == RMW ? (bus.dm_dout & ~mask) | ins : bus.req_wdata;
    bus.dm_wr = 1'b0;
    bus.stall = 1'b0;
    bus.exc = fault;
    bus.ld_data = '0;
    if (state_q == RMW) begin
      bus.dm_wr = rst_n;
      state_d = IDLE;
    end else if (idle_req && !fault) begin
      if (!bus.req_we)
        bus.ld_data = bus.req_size == 2'b00 ? {{24{bus.req_sign & shifted[7]}}, shifted[7:0]} :
                      bus.req_size == 2'b01 ? {{16{bus.req_sign & shifted[15]}}, shifted[15:0]} :
                      bus.dm_dout;
      else if (bus.req_size == 2'b10)
        bus.dm_wr = 1'b1;
      else begin
        bus.stall = 1'b1;
        state_d = RMW;
        addr_d = bus.req_addr[AW+1:2];
        lane_d = bus.req_addr[1:0];
        half_d = bus.req_size[0];
        wdata_d = bus.req_wdata[15:0];
      end
    end
    exc_flag_d = bus.exc_clr ? 1'b0 : exc_flag_q | fault;
    bad_addr_d = bus.exc_clr ? '0 : (fault && !exc_flag_q) ? bus.req_addr : bad_addr_q;
    bus.exc_flag = exc_flag_q;
    bus.bad_addr = bad_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      lane_q <= '0;
      half_q <= 1'b0;
      wdata_q <= '0;
      exc_flag_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      lane_q <= lane_d;
      half_q <= half_d;
      wdata_q <= wdata_d;
      exc_flag_q <= exc_flag_d;
      bad_addr_q <= bad_addr_d;
    end
  end
endmodule
